// File: rtl/project_select_pkg.sv
// Shared definitions for the Wishbone project selector.
// Holds the register map (word offsets on adr[3:2]), SELECT/STATUS bit
// positions, the sequencer state encoding and the gap counter sizing helper.
package project_select_pkg;

  localparam logic [1:0] REG_SELECT = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_LOCK   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int IDX_W       = 5;
  localparam int SEL_EN_BIT  = 8;
  localparam int ST_EN_BIT   = 8;
  localparam int ST_BUSY_BIT = 9;
  localparam int ST_LOCK_BIT = 10;
  localparam int ST_ERR_BIT  = 11;

  typedef enum logic [1:0] {
    SEQ_OFF   = 2'd0,
    SEQ_ON    = 2'd1,
    SEQ_BREAK = 2'd2
  } seq_state_t;

  // Bits needed for a counter running 0 .. gap-1 (at least one bit).
  function automatic int gap_cnt_w(input int gap);
    if (gap <= 2) return 1;
    return $clog2(gap);
  endfunction

endpackage

// File: rtl/project_select_seq.sv
// Break-before-make sequencer for the project enables.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr              an accepted, in-range SELECT write this cycle
//   i_index, i_enable written index / enable
//   i_ovr             LA override enable
//   i_ovr_active      LA-supplied active bus
//   o_active          registered one-hot (or zero / override) enables
//   o_busy            high while a break gap is running
module project_select_seq
  import project_select_pkg::*;
#(
  parameter int GAP_CYCLES = 4
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [IDX_W-1:0] i_index,
  input  logic             i_enable,
  input  logic             i_ovr,
  input  logic [31:0]      i_ovr_active,
  output logic [31:0]      o_active,
  output logic             o_busy
);

  localparam int               CNT_W    = gap_cnt_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_target, w_target_nxt;
  logic             r_ovr;
  logic [31:0]      r_active, w_active_nxt;
  logic             w_ovr_fall;

  assign w_ovr_fall = r_ovr & ~i_ovr;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_active_nxt = '0;

    if (r_state == SEQ_BREAK) begin
      if (r_cnt == CNT_LAST) w_state_nxt = SEQ_ON;
      else                   w_cnt_nxt   = r_cnt + 1'b1;
    end

    // A write during BREAK only retargets; the running gap is kept.
    if (i_wr) begin
      w_target_nxt = i_index;
      if (!i_enable) begin
        w_state_nxt = SEQ_OFF;
      end else if (r_state == SEQ_OFF ||
                   (r_state == SEQ_ON && i_index != r_target)) begin
        w_state_nxt = SEQ_BREAK;
        w_cnt_nxt   = '0;
      end
    end

    // Releasing the override forces a full gap so the LA-driven project
    // is off before the firmware-selected one comes back.
    if (w_ovr_fall && w_state_nxt != SEQ_OFF) begin
      w_state_nxt = SEQ_BREAK;
      w_cnt_nxt   = '0;
    end

    if (i_ovr)                       w_active_nxt = i_ovr_active;
    else if (w_state_nxt == SEQ_ON)  w_active_nxt = 32'd1 << w_target_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= SEQ_OFF;
      r_cnt    <= '0;
      r_target <= '0;
      r_ovr    <= 1'b0;
      r_active <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
      r_ovr    <= i_ovr;
      r_active <= w_active_nxt;
    end
  end

  assign o_active = r_active;
  assign o_busy   = (r_state == SEQ_BREAK);

endmodule

// File: rtl/wb_project_select.sv
// Wishbone-controlled selector generating the one-hot project enable bus.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i        Wishbone classic handshake
//   wbs_sel_i, wbs_adr_i, wbs_dat_i  byte lanes, address, write data
//   wbs_ack_o, wbs_dat_o        single-cycle ack, read data (0 when idle)
//   la_override_i, la_active_i  LA bring-up override of the enable bus
//   active_o, busy_o            project enables, break-gap indicator
module wb_project_select
  import project_select_pkg::*;
#(
  parameter int          NUM_PROJECTS = 32,
  parameter int          GAP_CYCLES   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
)
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        la_override_i,
  input  logic [31:0] la_active_i,
  output logic [31:0] active_o,
  output logic        busy_o
);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [IDX_W-1:0] r_index;
  logic             r_enable, r_locked, r_error;

  logic             w_accept, w_hit, w_wr, w_rd;
  logic [1:0]       w_off;
  logic             w_sel_try, w_range_ok, w_sel_apply, w_sel_err;
  logic [31:0]      w_rd_data;
  logic             w_busy;
  logic             w_unused;

  assign w_accept = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off    = wbs_adr_i[3:2];
  assign w_wr     = w_accept & w_hit & wbs_we_i;
  assign w_rd     = w_accept & w_hit & ~wbs_we_i;

  // The range check covers write bits [7:0], so an index above the 5-bit
  // field (e.g. 37) is caught rather than silently aliased.
  assign w_sel_try   = w_wr && (w_off == REG_SELECT) &&
                       (wbs_sel_i[1:0] == 2'b11) && !r_locked;
  assign w_range_ok  = ({24'd0, wbs_dat_i[7:0]} < 32'(NUM_PROJECTS));
  assign w_sel_apply = w_sel_try & w_range_ok;
  assign w_sel_err   = w_sel_try & ~w_range_ok;

  always_comb begin
    w_rd_data = '0;
    if (w_rd) begin
      case (w_off)
        REG_SELECT: begin
          w_rd_data[IDX_W-1:0]  = r_index;
          w_rd_data[SEL_EN_BIT] = r_enable;
        end
        REG_STATUS: begin
          w_rd_data[IDX_W-1:0]   = r_index;
          w_rd_data[ST_EN_BIT]   = r_enable;
          w_rd_data[ST_BUSY_BIT] = w_busy;
          w_rd_data[ST_LOCK_BIT] = r_locked;
          w_rd_data[ST_ERR_BIT]  = r_error;
        end
        REG_LOCK: w_rd_data = '0;
        REG_RSVD: w_rd_data = '0;
        default:  w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_index  <= '0;
      r_enable <= 1'b0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_ack <= w_accept;
      r_dat <= w_rd_data;
      if (w_sel_apply) begin
        r_index  <= wbs_dat_i[IDX_W-1:0];
        r_enable <= wbs_dat_i[SEL_EN_BIT];
      end
      if (w_wr && (w_off == REG_LOCK) && wbs_dat_i[0]) r_locked <= 1'b1;
      // Error is sticky until a STATUS read reports it.
      if (w_sel_err)                                   r_error <= 1'b1;
      else if (w_rd && (w_off == REG_STATUS))          r_error <= 1'b0;
    end
  end

  project_select_seq #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_seq (
    .i_clk        (wb_clk_i),
    .i_rst        (wb_rst_i),
    .i_wr         (w_sel_apply),
    .i_index      (wbs_dat_i[IDX_W-1:0]),
    .i_enable     (wbs_dat_i[SEL_EN_BIT]),
    .i_ovr        (la_override_i),
    .i_ovr_active (la_active_i),
    .o_active     (active_o),
    .o_busy       (w_busy)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign busy_o    = w_busy;

  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:9]};

endmodule

// File: tb/tb_wb_project_select.sv
module tb_wb_project_select;

  localparam int          NP   = 32;
  localparam int          GAP  = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc_i, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic        ovr;
  logic [31:0] la;
  logic [31:0] active;
  logic        busy;

  always #5 clk = ~clk;

  wb_project_select #(
    .NUM_PROJECTS (NP),
    .GAP_CYCLES   (GAP),
    .BASE_ADDR    (BASE)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc_i),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dat_o),
    .la_override_i (ovr),
    .la_active_i   (la),
    .active_o      (active),
    .busy_o        (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: registers plus a timestamp view of the enables.
  // m_ready is the first cycle in which the selected one-hot is visible;
  // any cycle before it while enabled is part of a gap.
  int          cyc_n = 0;
  bit          m_ack;
  logic [31:0] m_rdat;
  logic [4:0]  m_idx, m_tgt;
  bit          m_en, m_locked, m_err, m_on;
  int          m_ready;
  bit          m_ovr_q;
  logic [31:0] m_la_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
  endtask

  function automatic bit m_busy_at(input int t);
    return m_on && (t < m_ready);
  endfunction

  function automatic logic [31:0] m_active_at(input int t);
    if (m_ovr_q) return m_la_q;
    if (m_on && t >= m_ready) return 32'd1 << m_tgt;
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_ack = 0; m_rdat = '0; m_idx = '0; m_tgt = '0; m_en = 0;
    m_locked = 0; m_err = 0; m_on = 0; m_ready = 0; m_ovr_q = 0; m_la_q = '0;
  endtask

  task automatic seq_write(input int t, input logic [4:0] idx, input bit en);
    if (!en) m_on = 0;
    else if (!m_on) begin
      m_on = 1; m_ready = t + 1 + GAP;
    end else if (t >= m_ready && idx != m_tgt) m_ready = t + 1 + GAP;
    m_tgt = idx;
  endtask

  // Advance one clock, update the model with the inputs seen at that edge,
  // then compare all outputs at the following falling edge.
  task automatic tick();
    int t; bit acc, hit; logic [1:0] off; bit fall;
    t = cyc_n;
    @(posedge clk);
    if (rst) m_reset();
    else begin
      acc  = stb && cyc_i && !m_ack;
      hit  = ((adr >> 4) == (BASE >> 4));
      off  = adr[3:2];
      fall = m_ovr_q && !ovr;
      m_rdat = '0;
      if (acc && hit && !we) begin
        if (off == 2'd0) m_rdat = {23'd0, m_en, 3'd0, m_idx};
        else if (off == 2'd1) begin
          m_rdat = {20'd0, m_err, m_locked, m_busy_at(t), m_en, 3'd0, m_idx};
          m_err = 0;
        end
      end
      if (acc && hit && we) begin
        if (off == 2'd0 && sel[1:0] == 2'b11 && !m_locked) begin
          if (int'(dat[7:0]) >= NP) m_err = 1;
          else begin
            m_idx = dat[4:0]; m_en = dat[8];
            seq_write(t, dat[4:0], dat[8]);
          end
        end else if (off == 2'd2 && dat[0]) m_locked = 1;
      end
      if (fall && m_on) m_ready = t + 1 + GAP;
      m_ovr_q = ovr; m_la_q = la;
      m_ack = acc;
    end
    cyc_n++;
    @(negedge clk);
    chk("ack", {31'd0, ack}, {31'd0, m_ack});
    chk("rdata", dat_o, m_rdat);
    chk("active", active, m_active_at(cyc_n));
    chk("busy", {31'd0, busy}, {31'd0, m_busy_at(cyc_n)});
  endtask

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d);
    if (ack) tick();
    stb = 1; cyc_i = 1; we = w; adr = a; dat = d; sel = 4'hF;
    tick();
    stb = 0; cyc_i = 0; we = 0;
    chk("bus_ack", {31'd0, ack}, 32'd1);
  endtask

  initial begin
    rst = 1; stb = 0; cyc_i = 0; we = 0; sel = 4'h0; adr = '0; dat = '0;
    ovr = 0; la = '0;
    m_reset();
    @(negedge clk);
    repeat (3) tick();
    rst = 0;
    tick();

    // Reset state
    bus(0, BASE + 32'h4, '0);
    chk("reset_status", dat_o, 32'h0);
    chk("reset_active", active, 32'h0);
    tick();

    // Enable index 1: four gap cycles then the one-hot
    bus(1, BASE, 32'h101);
    for (int i = 0; i < GAP; i++) begin
      chk("gap_active", active, 32'h0);
      chk("gap_busy", {31'd0, busy}, 32'd1);
      if (i < GAP - 1) tick();
    end
    tick();
    chk("sel1_active", active, 32'h2);
    chk("sel1_busy", {31'd0, busy}, 32'd0);
    tick();

    // Switch to 5, retarget to 3 mid-gap: the gap is not extended
    bus(1, BASE, 32'h105);
    bus(1, BASE, 32'h103);
    tick();
    chk("retarget_gap", active, 32'h0);
    chk("retarget_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("retarget_active", active, 32'h8);
    tick();

    // Out-of-range index: ignored, sticky error cleared by STATUS read
    bus(1, BASE, 32'h125);
    chk("range_active", active, 32'h8);
    bus(0, BASE + 32'h4, '0);
    chk("err_set", {31'd0, dat_o[11]}, 32'd1);
    chk("err_status", dat_o, 32'h0000_0903);
    bus(0, BASE + 32'h4, '0);
    chk("err_clear", {31'd0, dat_o[11]}, 32'd0);

    // Lock blocks SELECT writes until reset
    bus(1, BASE + 32'h8, 32'h1);
    bus(1, BASE, 32'h104);
    bus(0, BASE + 32'h4, '0);
    chk("locked_bit", {31'd0, dat_o[10]}, 32'd1);
    chk("locked_index", {27'd0, dat_o[4:0]}, 32'd3);
    chk("locked_active", active, 32'h8);
    rst = 1; tick(); tick(); rst = 0; tick();
    bus(0, BASE + 32'h4, '0);
    chk("unlock_status", dat_o, 32'h0);
    chk("unlock_active", active, 32'h0);

    // Override over index 2, then release: full gap before restore
    bus(1, BASE, 32'h102);
    repeat (GAP) tick();
    chk("sel2_active", active, 32'h4);
    ovr = 1; la = 32'h8000_0000;
    tick();
    chk("ovr_active", active, 32'h8000_0000);
    tick(); tick();
    ovr = 0; la = 32'h0;
    tick();
    for (int i = 0; i < GAP; i++) begin
      chk("ovr_gap", active, 32'h0);
      if (i < GAP - 1) tick();
    end
    tick();
    chk("ovr_restore", active, 32'h4);

    // Outside the window: acked, reads 0, writes ignored
    bus(1, BASE + 32'h10, 32'h107);
    bus(0, BASE + 32'h10, '0);
    chk("oow_read", dat_o, 32'h0);
    bus(0, BASE + 32'hC, '0);
    chk("rsvd_read", dat_o, 32'h0);
    bus(0, BASE, '0);
    chk("select_read", dat_o, 32'h0000_0102);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] d;
      int r;
      rst = ($urandom_range(0, 199) == 0);
      stb = ($urandom_range(0, 2) == 0);
      cyc_i = stb;
      we = $urandom_range(0, 1);
      r = $urandom_range(0, 4);
      adr = (r < 4) ? BASE + 32'(4 * r) : $urandom;
      d = $urandom;
      d[7:0] = 8'($urandom_range(0, 40));
      d[8] = ($urandom_range(0, 3) != 0);
      if (adr[3:2] == 2'd2) d[0] = 1'b0;
      dat = d;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 24) == 0) ovr = ~ovr;
      la = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
